// File: rtl/signal_sequencer.sv
// signal_sequencer: start/stop ROM sample sequencer with rate divider and burst length (SIGSEQ_LOOP_EN adds i_loop)
module signal_sequencer #(
  parameter int NB_DATA = 16,
  parameter int NB_ADDR = 10,
  parameter int NB_DIV  = 8
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_start,
  input  logic               i_stop,
`ifdef SIGSEQ_LOOP_EN
  input  logic               i_loop,
`endif
  input  logic [NB_DIV-1:0]  i_rate_div,
  input  logic [NB_ADDR-1:0] i_last_addr,
  input  logic [NB_DATA-1:0] i_mem_data,
  output logic [NB_ADDR-1:0] o_addr,
  output logic [NB_DATA-1:0] o_sample,
  output logic               o_valid,
  output logic               o_busy,
  output logic               o_done
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t             state_q, state_d;
  logic [NB_ADDR-1:0] addr_q, addr_d, last_q, last_d;
  logic [NB_DATA-1:0] sample_q, sample_d;
  logic [NB_DIV-1:0]  div_cnt_q, div_cnt_d, rdiv_q, rdiv_d;
  logic               valid_q, valid_d, done_q, done_d, loop_q;
  logic               accept, tick, at_last;
  assign accept  = state_q == IDLE && i_start && !i_stop;
  assign tick    = div_cnt_q == rdiv_q;
  assign at_last = addr_q == last_q;
`ifdef SIGSEQ_LOOP_EN
  logic loop_d;
  assign loop_d = accept ? i_loop : loop_q;
  // loop mode is captured with the rest of the burst configuration
  always_ff @(posedge i_clock) begin
    loop_q <= i_reset ? 1'b0 : loop_d;
  end
`else
  assign loop_q = 1'b0;
`endif
  // next-state and datapath: stop wins over tick, start only honoured in IDLE
  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    last_d    = last_q;
    rdiv_d    = rdiv_q;
    div_cnt_d = div_cnt_q;
    sample_d  = sample_q;
    valid_d   = 1'b0;
    done_d    = 1'b0;
    if (state_q == IDLE) begin
      if (accept) begin
        rdiv_d    = i_rate_div;
        last_d    = i_last_addr;
        addr_d    = '0;
        div_cnt_d = '0;
        state_d   = RUN;
      end
    end else if (i_stop) begin
      state_d   = IDLE;
      addr_d    = '0;
      div_cnt_d = '0;
    end else if (!tick) begin
      div_cnt_d = div_cnt_q + 1'b1;
    end else begin
      div_cnt_d = '0;
      sample_d  = i_mem_data;
      valid_d   = 1'b1;
      addr_d    = at_last ? '0 : addr_q + 1'b1;
      done_d    = at_last;
      state_d   = at_last && !loop_q ? IDLE : RUN;
    end
  end
  // state and output registers
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      last_q    <= '0;
      rdiv_q    <= '0;
      div_cnt_q <= '0;
      sample_q  <= '0;
      valid_q   <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      last_q    <= last_d;
      rdiv_q    <= rdiv_d;
      div_cnt_q <= div_cnt_d;
      sample_q  <= sample_d;
      valid_q   <= valid_d;
      done_q    <= done_d;
    end
  end
  assign o_addr   = addr_q;
  assign o_sample = sample_q;
  assign o_valid  = valid_q;
  assign o_busy   = state_q == RUN;
  assign o_done   = done_q;
endmodule
